// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: one-cold row drive, 2-flop column sync, tick-based debounce, press strobe.
// Optional auto-repeat while a key is held is enabled by defining KEY_REPEAT_EN.
module key_matrix_scan #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEB_TICKS  = 20,
  parameter int unsigned REP_DELAY  = 500,
  parameter int unsigned REP_PERIOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [7:0] row_col,
  output logic       key_value,
  output logic       key_busy
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W = $clog2(DEB_TICKS + 1);

  if (SCAN_DIV < 2 || DEB_TICKS < 1 || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_param_check
    $error("key_matrix_scan: illegal parameter value");
  end

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2,
    ST_DEB_REL   = 2'd3
  } state_t;

  logic [3:0]       r_col_meta;
  logic [3:0]       r_col_s;
  logic [DIV_W-1:0] r_div;
  state_t           r_state;
  logic [3:0]       r_row;
  logic [3:0]       r_col_l;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [7:0]       r_row_col;
  logic             r_key_value;
  logic             r_key_busy;

  state_t           w_state_nxt;
  logic [3:0]       w_row_nxt;
  logic [3:0]       w_col_l_nxt;
  logic [DEB_W-1:0] w_deb_nxt;
  logic [7:0]       w_row_col_nxt;
  logic             w_key_value_nxt;

  logic             w_tick;
  logic             w_col_valid;
  logic             w_col_idle;
  logic             w_col_same;
  logic [3:0]       w_row_rot;
  logic [DEB_W-1:0] w_deb_inc;
  logic             w_deb_done;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic [REP_W-1:0] w_rep_cnt_nxt;
  logic             w_rep_first_nxt;
  logic [REP_W-1:0] w_rep_inc;
  logic [REP_W-1:0] w_rep_limit;
  logic             w_rep_fire;

  // First re-strobe waits REP_DELAY ticks, later ones REP_PERIOD ticks.
  assign w_rep_inc   = r_rep_cnt + REP_W'(1);
  assign w_rep_limit = r_rep_first ? REP_W'(REP_DELAY) : REP_W'(REP_PERIOD);
  assign w_rep_fire  = (w_rep_inc == w_rep_limit);
`endif

  // Exactly one low column is a key; anything else reads as no key.
  always_comb begin
    unique case (r_col_s)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_col_valid = 1'b1;
      default:                            w_col_valid = 1'b0;
    endcase
  end

  assign w_tick     = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_col_idle = (r_col_s == 4'hF);
  assign w_col_same = (r_col_s == r_col_l);
  assign w_row_rot  = {r_row[2:0], r_row[3]};
  assign w_deb_inc  = r_deb_cnt + DEB_W'(1);
  assign w_deb_done = (w_deb_inc >= DEB_W'(DEB_TICKS - 1));

  // Column synchroniser and free-running scan tick divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col_meta <= 4'hF;
      r_col_s    <= 4'hF;
      r_div      <= '0;
    end else begin
      r_col_meta <= col_in;
      r_col_s    <= r_col_meta;
      r_div      <= w_tick ? '0 : r_div + DIV_W'(1);
    end
  end

  // FSM state and the registers it owns.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SCAN;
      r_row       <= 4'b1110;
      r_col_l     <= 4'hF;
      r_deb_cnt   <= '0;
      r_row_col   <= 8'hFF;
      r_key_value <= 1'b0;
      r_key_busy  <= 1'b0;
`ifdef KEY_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col_l     <= w_col_l_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_row_col   <= w_row_col_nxt;
      r_key_value <= w_key_value_nxt;
      r_key_busy  <= (w_state_nxt != ST_SCAN);
`ifdef KEY_REPEAT_EN
      r_rep_cnt   <= w_rep_cnt_nxt;
      r_rep_first <= w_rep_first_nxt;
`endif
    end
  end

  // Next-state and output decode; everything advances only on a scan tick.
  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_col_l_nxt     = r_col_l;
    w_deb_nxt       = r_deb_cnt;
    w_row_col_nxt   = r_row_col;
    w_key_value_nxt = 1'b0;
`ifdef KEY_REPEAT_EN
    w_rep_cnt_nxt   = '0;
    w_rep_first_nxt = 1'b1;
`endif

    case (r_state)
      ST_SCAN: begin
        if (w_tick) begin
          if (w_col_valid) begin
            w_col_l_nxt = r_col_s;
            w_deb_nxt   = '0;
            w_state_nxt = ST_DEB_PRESS;
          end else begin
            w_row_nxt = w_row_rot;
          end
        end
      end

      ST_DEB_PRESS: begin
        if (w_tick) begin
          if (w_col_same) begin
            if (w_deb_done) begin
              w_row_col_nxt   = {r_row, r_col_l};
              w_key_value_nxt = 1'b1;
              w_state_nxt     = ST_HELD;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_state_nxt = ST_SCAN;
          end
        end
      end

      ST_HELD: begin
`ifdef KEY_REPEAT_EN
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_first_nxt = r_rep_first;
`endif
        if (w_tick) begin
          if (w_col_idle) begin
            w_deb_nxt   = '0;
            w_state_nxt = ST_DEB_REL;
`ifdef KEY_REPEAT_EN
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b1;
`endif
          end
`ifdef KEY_REPEAT_EN
          else if (w_rep_fire) begin
            w_key_value_nxt = 1'b1;
            w_rep_cnt_nxt   = '0;
            w_rep_first_nxt = 1'b0;
          end else begin
            w_rep_cnt_nxt = w_rep_inc;
          end
`endif
        end
      end

      ST_DEB_REL: begin
        if (w_tick) begin
          if (w_col_idle) begin
            if (w_deb_done) begin
              w_state_nxt = ST_SCAN;
              w_row_nxt   = w_row_rot;
            end else begin
              w_deb_nxt = w_deb_inc;
            end
          end else begin
            w_state_nxt = ST_HELD;
          end
        end
      end

      default: w_state_nxt = ST_SCAN;
    endcase
  end

  assign row_out   = r_row;
  assign row_col   = r_row_col;
  assign key_value = r_key_value;
  assign key_busy  = r_key_busy;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: keypad emulation, directed scenarios and random traffic
// checked cycle by cycle against a tick-level behavioural model.
module tb_key_matrix_scan;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_TICKS  = 3;
  localparam int REP_DELAY  = 5;
  localparam int REP_PERIOD = 2;

  localparam int M_SCAN  = 0;
  localparam int M_PRESS = 1;
  localparam int M_HELD  = 2;
  localparam int M_REL   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in = 4'hF;
  logic [3:0] row_out;
  logic [7:0] row_col;
  logic       key_value;
  logic       key_busy;

  logic       key_on  = 1'b0;
  logic [3:0] key_row = 4'hF;
  logic [3:0] key_col = 4'hF;
  logic [3:0] raw_col = 4'hF;
  logic       mon_en  = 1'b0;
  logic       kv_prev = 1'b0;

  int errors = 0;
  int checks = 0;

  key_matrix_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_TICKS (DEB_TICKS),
    .REP_DELAY (REP_DELAY),
    .REP_PERIOD(REP_PERIOD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .col_in   (col_in),
    .row_out  (row_out),
    .row_col  (row_col),
    .key_value(key_value),
    .key_busy (key_busy)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key pulls its column low only while its row is driven.
  always @(negedge clk) col_in = key_on ? ((row_out == key_row) ? key_col : 4'hF) : raw_col;

  function automatic logic [3:0] row_code(input int idx);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Reference model: works per scan tick on row index and run lengths of stable ticks.
  int         m_mode, m_row_idx, m_run, m_held, m_div;
  logic [3:0] m_meta, m_sync, m_latched, m_row_out;
  logic [7:0] m_row_col;
  logic       m_kv, m_busy;

  always @(posedge clk) begin : model
    logic       tick;
    logic [3:0] cs;
    if (rst) begin
      m_mode = M_SCAN; m_row_idx = 0; m_run = 0; m_held = 0; m_div = 0;
      m_meta = 4'hF; m_sync = 4'hF; m_latched = 4'hF; m_row_col = 8'hFF; m_kv = 1'b0;
    end else begin
      tick  = (m_div == SCAN_DIV - 1);
      m_div = tick ? 0 : m_div + 1;
      cs    = m_sync;
      m_kv  = 1'b0;
      if (tick) begin
        case (m_mode)
          M_SCAN:
            if ($countones(~cs) == 1) begin
              m_latched = cs; m_run = 1; m_mode = M_PRESS;
            end else m_row_idx = (m_row_idx + 1) % 4;
          M_PRESS:
            if (cs == m_latched) begin
              m_run++;
              if (m_run >= DEB_TICKS) begin
                m_row_col = {row_code(m_row_idx), m_latched};
                m_kv = 1'b1; m_mode = M_HELD; m_held = 0;
              end
            end else m_mode = M_SCAN;
          M_HELD:
            if (cs == 4'hF) begin
              m_mode = M_REL; m_run = 1;
            end else begin
              m_held++;
`ifdef KEY_REPEAT_EN
              if (m_held == REP_DELAY ||
                  (m_held > REP_DELAY && (m_held - REP_DELAY) % REP_PERIOD == 0))
                m_kv = 1'b1;
`endif
            end
          default:
            if (cs == 4'hF) begin
              m_run++;
              if (m_run >= DEB_TICKS) begin
                m_mode = M_SCAN; m_row_idx = (m_row_idx + 1) % 4;
              end
            end else begin
              m_mode = M_HELD; m_held = 0;
            end
        endcase
      end
      m_sync = m_meta;
      m_meta = col_in;
    end
    m_row_out = row_code(m_row_idx);
    m_busy    = (m_mode != M_SCAN);
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL reset_row_out: got %b want 1110", row_out); end
    checks++; if (row_col !== 8'hFF) begin errors++; $display("FAIL reset_row_col: got %h want ff", row_col); end
    checks++; if (key_value !== 1'b0) begin errors++; $display("FAIL reset_key_value: got %b want 0", key_value); end
    checks++; if (key_busy !== 1'b0) begin errors++; $display("FAIL reset_key_busy: got %b want 0", key_busy); end
    repeat (4) @(negedge clk);
    checks++; if (row_out !== 4'b1101) begin errors++; $display("FAIL reset_rotate1: got %b want 1101", row_out); end
    repeat (4) @(negedge clk);
    checks++; if (row_out !== 4'b1011) begin errors++; $display("FAIL reset_rotate2: got %b want 1011", row_out); end
  endtask

  task automatic test_clean_press();
    int  pulses;
    bit  got;
    key_row = 4'b1011; key_col = 4'b0111; key_on = 1'b1;
    got = 0;
    for (int i = 0; i < 150 && !got; i++) begin @(negedge clk); if (key_value) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL clean_strobe: no key_value within 150 cycles"); end
    checks++; if (row_col !== 8'hB7) begin errors++; $display("FAIL clean_row_col: got %h want b7", row_col); end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin @(negedge clk); if (key_value) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL clean_held_pulses: got %0d want 0", pulses); end
    checks++; if (key_busy !== 1'b1) begin errors++; $display("FAIL clean_held_busy: got %b want 1", key_busy); end
    key_on = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); if (!key_busy) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL clean_release: key_busy still %b after 40 cycles, want 0", key_busy); end
  endtask

  task automatic test_bounce();
    int pulses;
    bit got;
    key_row = 4'b0111; key_col = 4'b0111;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      if (i % 4 == 0) key_on = ~key_on;
      @(negedge clk);
      if (key_value) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL bounce_pulses: got %0d want 0", pulses); end
    key_on = 1'b1;
    got = 0;
    for (int i = 0; i < 150 && !got; i++) begin @(negedge clk); if (key_value) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL bounce_strobe: no key_value within 150 cycles"); end
    checks++; if (row_col !== 8'h77) begin errors++; $display("FAIL bounce_row_col: got %h want 77", row_col); end
    key_on = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); if (!key_busy) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL bounce_release: key_busy still %b, want 0", key_busy); end
  endtask

  task automatic test_invalid();
    int         pulses, busy_hi, moves;
    logic [3:0] prev;
    raw_col = 4'b0011;
    pulses = 0; busy_hi = 0; moves = 0;
    @(negedge clk);
    prev = row_out;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (key_value) pulses++;
      if (key_busy) busy_hi++;
      if (row_out != prev) moves++;
      prev = row_out;
    end
    raw_col = 4'hF;
    checks++; if (pulses != 0) begin errors++; $display("FAIL invalid_pulses: got %0d want 0", pulses); end
    checks++; if (busy_hi != 0) begin errors++; $display("FAIL invalid_busy: busy cycles %0d want 0", busy_hi); end
    checks++; if (moves != 12) begin errors++; $display("FAIL invalid_rotate: row moves %0d want 12", moves); end
    checks++; if (row_col !== 8'h77) begin errors++; $display("FAIL invalid_row_col: got %h want 77", row_col); end
  endtask

  task automatic test_release_bounce_reset();
    int pulses, busy_lo;
    bit got;
    key_row = 4'b1101; key_col = 4'b1011; key_on = 1'b1;
    got = 0;
    for (int i = 0; i < 150 && !got; i++) begin @(negedge clk); if (key_value) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL relb_strobe: no key_value within 150 cycles"); end
    checks++; if (row_col !== 8'hDB) begin errors++; $display("FAIL relb_row_col: got %h want db", row_col); end
    pulses = 0; busy_lo = 0;
    for (int i = 0; i < 16; i++) begin
      key_on = !(i >= 4 && i < 8);
      @(negedge clk);
      if (key_value) pulses++;
      if (!key_busy) busy_lo++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL relb_pulses: got %0d want 0", pulses); end
    checks++; if (busy_lo != 0) begin errors++; $display("FAIL relb_busy: idle cycles %0d want 0", busy_lo); end
    key_on = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); if (!key_busy) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL relb_release: key_busy still %b, want 0", key_busy); end
    key_on = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clk); if (key_busy) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL relb_debounce_entry: key_busy stayed 0, want 1"); end
    repeat (2) @(negedge clk);
    rst = 1'b1; key_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (row_out !== 4'b1110) begin errors++; $display("FAIL rst_mid_row_out: got %b want 1110", row_out); end
    checks++; if (row_col !== 8'hFF) begin errors++; $display("FAIL rst_mid_row_col: got %h want ff", row_col); end
    checks++; if (key_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", key_busy); end
    pulses = (key_value === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (key_value) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rst_mid_pulses: got %0d want 0", pulses); end
  endtask

`ifdef KEY_REPEAT_EN
  task automatic test_repeat();
    int offs[$];
    int exp_off[4] = '{20, 28, 36, 44};
    bit got;
    key_row = 4'b0111; key_col = 4'b1011; key_on = 1'b1;
    got = 0;
    for (int i = 0; i < 150 && !got; i++) begin @(negedge clk); if (key_value) got = 1; end
    checks++; if (!got) begin errors++; $display("FAIL rep_strobe: no key_value within 150 cycles"); end
    checks++; if (row_col !== 8'h7B) begin errors++; $display("FAIL rep_accept_code: got %h want 7b", row_col); end
    for (int c = 1; c <= 48; c++) begin
      @(negedge clk);
      if (key_value) begin
        offs.push_back(c);
        checks++; if (row_col !== 8'h7B) begin errors++; $display("FAIL rep_code: got %h want 7b", row_col); end
      end
    end
    checks++; if (offs.size() != 4) begin errors++; $display("FAIL rep_count: got %0d want 4", offs.size()); end
    for (int i = 0; i < offs.size() && i < 4; i++) begin
      checks++;
      if (offs[i] != exp_off[i]) begin errors++; $display("FAIL rep_offset%0d: got %0d want %0d", i, offs[i], exp_off[i]); end
    end
    key_on = 1'b0;
    repeat (40) @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int kind, hold;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        key_row = 4'(~(4'b0001 << $urandom_range(0, 3)));
        key_col = 4'(~(4'b0001 << $urandom_range(0, 3)));
        key_on  = 1'b1;
        hold    = $urandom_range(8, 80);
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          if ($urandom_range(0, 15) == 0) key_on = ~key_on;
        end
        key_on = 1'b0;
        repeat ($urandom_range(4, 60)) @(negedge clk);
      end else if (kind < 8) begin
        raw_col = 4'($urandom);
        repeat ($urandom_range(4, 40)) @(negedge clk);
        raw_col = 4'hF;
      end else if (kind == 8) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end else begin
        repeat ($urandom_range(4, 30)) @(negedge clk);
      end
    end
    key_on = 1'b0; raw_col = 4'hF;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          checks++; if (row_out !== m_row_out) begin errors++; $display("FAIL model_row_out: got %b want %b at %0t", row_out, m_row_out, $time); end
          checks++; if (row_col !== m_row_col) begin errors++; $display("FAIL model_row_col: got %h want %h at %0t", row_col, m_row_col, $time); end
          checks++; if (key_value !== m_kv) begin errors++; $display("FAIL model_key_value: got %b want %b at %0t", key_value, m_kv, $time); end
          checks++; if (key_busy !== m_busy) begin errors++; $display("FAIL model_key_busy: got %b want %b at %0t", key_busy, m_busy, $time); end
          checks++; if (key_value && kv_prev) begin errors++; $display("FAIL strobe_width: key_value high 2 cycles at %0t, want 1", $time); end
        end
        kv_prev = key_value;
      end
    join_none

    test_reset();
    test_clean_press();
    test_bounce();
    test_invalid();
    test_release_bounce_reset();
`ifdef KEY_REPEAT_EN
    test_repeat();
`endif
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
